// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Shares the transmit-load path of an SPI slave core between several on-chip
// requesters. A round-robin arbiter picks one pending requester, captures its
// word, strobes it into the SPI core and then follows the core's trdy
// handshake until the word has been shifted out. If the core stops answering,
// a sticky timeout flag is raised and the arbiter returns to idle.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous reset, active high
//   enable         1 allows new transfers to start
//   req            req[i]=1 when requester i has a word pending
//   req_data       word of requester i at [i*W +: W]
//   gnt            one-hot, one-cycle pulse when requester i's word is captured
//   busy           1 while a transfer is in progress
//   tmo_err        sticky timeout flag
//   tmo_clr        one-cycle clear for tmo_err
//   spi_tx_load_en one-cycle load strobe to the SPI core
//   spi_tx_data    word presented to the SPI core
//   spi_trdy       SPI core transmit buffer empty / ready

module spi_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int TMO_W = 16,
  parameter int TMO   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              tmo_err,
  input  logic              tmo_clr,
  output logic              spi_tx_load_en,
  output logic [W-1:0]      spi_tx_data,
  input  logic              spi_trdy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  // Last count value before a timeout fires; unused when TMO is 0.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO == 0) ? 0 : TMO - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     rrPtr_q;
  logic [IW-1:0]     idx_q;
  logic [TMO_W-1:0]  tmoCnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic              busy_q;
  logic              tmoErr_q;
  logic              load_q;
  logic [W-1:0]      data_q;

  logic              winFound_d;
  logic [IW-1:0]     winIdx_d;
  logic [W-1:0]      winData_d;
  logic              levelSeen_d;

  // Round-robin search: walk the request vector starting at rrPtr_q and
  // wrapping around; the first pending requester wins.
  always_comb begin
    int j;
    j          = 0;
    winFound_d = 1'b0;
    winIdx_d   = '0;
    winData_d  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rrPtr_q) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (!winFound_d && req[j]) begin
        winFound_d = 1'b1;
        winIdx_d   = IW'(j);
        winData_d  = req_data[j*W +: W];
      end
    end
  end

  // The level each wait state is looking for: low means the core took the
  // word, high means the core has shifted it out and is ready again.
  always_comb begin
    levelSeen_d = 1'b0;
    if (state_q == WAIT_LO) begin
      levelSeen_d = !spi_trdy;
    end else if (state_q == WAIT_HI) begin
      levelSeen_d = spi_trdy;
    end
  end

  // Transfer FSM with all outputs registered. gnt and the load strobe are
  // raised on the capture edge so they are high exactly during LOAD.
  // tmo_clr is applied first so that a timeout on the same edge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      idx_q    <= '0;
      tmoCnt_q <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      tmoErr_q <= 1'b0;
      load_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      gnt_q  <= '0;
      load_q <= 1'b0;
      if (tmo_clr) begin
        tmoErr_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (enable && spi_trdy && winFound_d) begin
            idx_q   <= winIdx_d;
            data_q  <= winData_d;
            gnt_q   <= ONE_HOT0 << winIdx_d;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          rrPtr_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          tmoCnt_q <= '0;
          state_q  <= WAIT_LO;
        end
        WAIT_LO, WAIT_HI: begin
          if (levelSeen_d) begin
            tmoCnt_q <= '0;
            if (state_q == WAIT_LO) begin
              state_q <= WAIT_HI;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (TMO != 0) begin
            // Counter stops at its last value: the timeout fires there.
            if (tmoCnt_q == TMO_LAST) begin
              tmoErr_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
            end else begin
              tmoCnt_q <= tmoCnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign busy           = busy_q;
  assign tmo_err        = tmoErr_q;
  assign spi_tx_load_en = load_q;
  assign spi_tx_data    = data_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter
// Self-checking bench for spi_tx_arbiter (NREQ=4, W=8, TMO=16). A transaction
// level model predicts every registered output each cycle; directed sequences
// add hand-computed literal expectations. An optional SPI core emulation
// drops trdy for a few cycles after each load strobe.

module tb_spi_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int TMO_W = 16;
  localparam int TMO   = 16;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              tmo_err;
  logic              tmo_clr;
  logic              spi_tx_load_en;
  logic [W-1:0]      spi_tx_data;
  logic              spi_trdy;

  logic              autoCore;
  logic              autoTrdy;
  logic              manualTrdy;
  int                coreCnt;

  int                checks;
  int                errors;

  // Model state, written only by the compare process.
  bit                mActive;
  bit                mLoadCyc;
  bit                mSeenLow;
  bit                mErr;
  bit                mLoad;
  int                mWait;
  int                mLast;
  int                mWinner;
  logic [NREQ-1:0]   mGnt;
  logic [W-1:0]      mData;

  spi_tx_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .TMO_W(TMO_W),
    .TMO  (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .busy          (busy),
    .tmo_err       (tmo_err),
    .tmo_clr       (tmo_clr),
    .spi_tx_load_en(spi_tx_load_en),
    .spi_tx_data   (spi_tx_data),
    .spi_trdy      (spi_trdy)
  );

  assign spi_trdy = autoCore ? autoTrdy : manualTrdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gntIndex(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  // Emulated SPI core: after seeing the load strobe it reports "busy" (trdy
  // low) for three cycles, then ready again.
  always @(negedge clk) begin
    if (rst || !autoCore) begin
      autoTrdy = 1'b1;
      coreCnt  = 0;
    end else if (spi_tx_load_en) begin
      coreCnt  = 2;
      autoTrdy = 1'b0;
    end else if (coreCnt > 0) begin
      coreCnt  = coreCnt - 1;
      autoTrdy = 1'b0;
    end else begin
      autoTrdy = 1'b1;
    end
  end

  task automatic modelReset();
    mActive  = 0;
    mLoadCyc = 0;
    mSeenLow = 0;
    mErr     = 0;
    mLoad    = 0;
    mWait    = 0;
    mLast    = NREQ - 1;
    mWinner  = 0;
    mGnt     = '0;
    mData    = '0;
  endtask

  // One clock edge of the model, from the inputs present before the edge.
  // A transfer is: capture, one load cycle, then wait for the core to take
  // the word (trdy low) and finish it (trdy high), each wait bounded by TMO.
  task automatic modelStep();
    bit newErr;
    newErr = mErr && !tmo_clr;
    mGnt   = '0;
    mLoad  = 0;
    if (!mActive) begin
      if (enable && spi_trdy && (req != 0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req[(mLast + k) % NREQ]) begin
            mWinner = (mLast + k) % NREQ;
            break;
          end
        end
        mData    = req_data[mWinner*W +: W];
        mGnt     = NREQ'(1 << mWinner);
        mLoad    = 1;
        mActive  = 1;
        mLoadCyc = 1;
      end
    end else if (mLoadCyc) begin
      mLoadCyc = 0;
      mLast    = mWinner;
      mSeenLow = 0;
      mWait    = 0;
    end else if (mSeenLow ? spi_trdy : !spi_trdy) begin
      if (!mSeenLow) begin
        mSeenLow = 1;
        mWait    = 0;
      end else begin
        mActive = 0;
      end
    end else if (mWait == TMO - 1) begin
      newErr  = 1;
      mActive = 0;
    end else begin
      mWait++;
    end
    mErr = newErr;
  endtask

  // Compare process: advance the model on each rising edge, then compare
  // shortly after the edge once the registered outputs have settled.
  always @(posedge clk) begin
    if (rst) modelReset();
    else modelStep();
    #1;
    checkOutput("gnt", 32'(gnt), 32'(mGnt));
    checkOutput("load_en", 32'(spi_tx_load_en), 32'(mLoad));
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("tmo_err", 32'(tmo_err), 32'(mErr));
    checkOutput("tx_data", 32'(spi_tx_data), 32'(mData));
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic en);
    req    = r;
    enable = en;
  endtask

  task automatic waitIdle(input string name);
    int c;
    c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nG;
    int gLog[8];
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    tmo_clr    = 1'b0;
    autoCore   = 1'b1;
    manualTrdy = 1'b1;
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    applyStimulus('0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_load", 32'(spi_tx_load_en), 32'd0);
    checkOutput("reset_data", 32'(spi_tx_data), 32'd0);
    rst = 1'b0;

    // Reset asserted while waiting for trdy to return high.
    $display("[TB] reset during transfer");
    autoCore = 1'b0;
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("t1_load", 32'(spi_tx_load_en), 32'd1);
    checkOutput("t1_data", 32'(spi_tx_data), 32'h22);
    applyStimulus('0, 1'b1);
    manualTrdy = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t1_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t1_rst_busy", 32'(busy), 32'd0);
    checkOutput("t1_rst_data", 32'(spi_tx_data), 32'd0);
    checkOutput("t1_rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    manualTrdy = 1'b1;
    rst        = 1'b0;
    autoCore   = 1'b1;

    // Round robin with all four requesting; the first grant after reset is 0.
    $display("[TB] round robin");
    applyStimulus(4'b1111, 1'b1);
    nG = 0;
    for (int c = 0; c < 200 && nG < 5; c++) begin
      @(negedge clk);
      if (gnt != 0) begin
        gLog[nG] = gntIndex(gnt);
        nG++;
        if (nG == 5) applyStimulus('0, 1'b1);
      end
    end
    checkOutput("t3_grants", 32'(nG), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t3_order%0d", i), 32'(gLog[i]), 32'(expOrder[i]));
    end
    waitIdle("t3_idle");

    // Single requester with a distinctive word.
    $display("[TB] single requester");
    req_data[2*W +: W] = 8'hA5;
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("t2_gnt", 32'(gnt), 32'h4);
    checkOutput("t2_load", 32'(spi_tx_load_en), 32'd1);
    checkOutput("t2_data", 32'(spi_tx_data), 32'hA5);
    applyStimulus('0, 1'b1);
    waitIdle("t2_idle");

    // Timeout in the wait-for-low phase: trdy never drops.
    $display("[TB] timeout");
    autoCore   = 1'b0;
    manualTrdy = 1'b1;
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("t4_load", 32'(spi_tx_load_en), 32'd1);
    applyStimulus('0, 1'b1);
    repeat (16) @(negedge clk);
    checkOutput("t4_err_pre", 32'(tmo_err), 32'd0);
    checkOutput("t4_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t4_err_set", 32'(tmo_err), 32'd1);
    checkOutput("t4_busy_post", 32'(busy), 32'd0);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    checkOutput("t4_err_clr", 32'(tmo_err), 32'd0);

    // Timeout in the wait-for-high phase, colliding with a clear.
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("t4b_load", 32'(spi_tx_load_en), 32'd1);
    applyStimulus('0, 1'b1);
    manualTrdy = 1'b0;
    repeat (17) @(negedge clk);
    checkOutput("t4b_err_pre", 32'(tmo_err), 32'd0);
    checkOutput("t4b_busy_pre", 32'(busy), 32'd1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    checkOutput("t4b_set_wins", 32'(tmo_err), 32'd1);
    checkOutput("t4b_busy_post", 32'(busy), 32'd0);
    manualTrdy = 1'b1;
    autoCore   = 1'b1;

    // Enable gating; tmo_err stays set and must not block arbitration.
    $display("[TB] enable gating");
    applyStimulus(4'b0001, 1'b0);
    nG = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt != 0 || spi_tx_load_en) nG++;
    end
    checkOutput("t5_disabled", 32'(nG), 32'd0);
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("t5_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0001, 1'b0);
    nG = 1;
    repeat (15) begin
      @(negedge clk);
      if (gnt != 0) nG++;
    end
    checkOutput("t5_once", 32'(nG), 32'd1);
    checkOutput("t5_idle", 32'(busy), 32'd0);
    checkOutput("t5_err_sticky", 32'(tmo_err), 32'd1);
    applyStimulus('0, 1'b1);

    // Withdrawal: a one-cycle pulse while busy is never granted.
    $display("[TB] withdrawal");
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("t6_load", 32'(spi_tx_load_en), 32'd1);
    applyStimulus('0, 1'b1);
    @(negedge clk);
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    applyStimulus('0, 1'b1);
    nG = 0;
    repeat (12) begin
      @(negedge clk);
      if (gnt[1]) nG++;
    end
    checkOutput("t6_pulse_ignored", 32'(nG), 32'd0);
    req_data[1*W +: W] = 8'h3C;
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("t6_gnt", 32'(gnt), 32'h2);
    checkOutput("t6_data", 32'(spi_tx_data), 32'h3C);
    applyStimulus('0, 1'b1);
    waitIdle("t6_idle");
    repeat (3) @(negedge clk);
    checkOutput("t6_data_held", 32'(spi_tx_data), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
